input_port_ctrl: RTL and testbench

//  Producer side of the CPU input-port handshake. Drives sw/ready_in into the register file and consumes its ack.

---
 rtl/input_port_ctrl.sv | 171 +++++++++++++++++
 tb/tb_input_port_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl.sv
// ---------------------------------------------------------------------------
// input_port_ctrl
//   Producer side of the CPU input-port handshake. Synchronises the raw
//   switch bank and the "enter" push-button, debounces button press and
//   release, and on each clean press captures the switches into sw and
//   raises ready_in until the CPU acknowledges with in_ack.
//
// Ports
//   clk       in   1          system clock, rising edge
//   reset     in   1          synchronous active-high reset
//   btn_raw   in   1          asynchronous enter button, 1 = pressed
//   sw_raw    in   BUS_WIDTH  asynchronous switch bank
//   in_ack    in   1          CPU consumed sw this cycle
//   sw        out  BUS_WIDTH  captured switch value
//   ready_in  out  1          sw holds unconsumed data
//   overrun   out  1          sticky: capture happened while data unconsumed
// ---------------------------------------------------------------------------
module input_port_ctrl #(
  parameter int BUS_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_raw,
  input  logic [BUS_WIDTH-1:0] sw_raw,
  input  logic                 in_ack,
  output logic [BUS_WIDTH-1:0] sw,
  output logic                 ready_in,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    RELEASE_DB = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers
  // -------------------------------------------------------------------------
  logic btn_meta_reg;
  logic btn_s_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_reg <= 1'b0;
      btn_s_reg    <= 1'b0;
    end else begin
      btn_meta_reg <= btn_raw;
      btn_s_reg    <= btn_meta_reg;
    end
  end

  // Each switch bit is synchronised independently; the switches are expected
  // to be static around a press, so no cross-bit coherence is attempted.
  logic [BUS_WIDTH-1:0] sw_s;

  generate
    for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_sw_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= sw_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sw_s[gi] = sync_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (btn_s_reg) begin
          state_next = PRESS_DB;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          capture    = 1'b1;
          state_next = RELEASE_DB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      RELEASE_DB: begin
        // Any high sample restarts the release count, so holding the button
        // can never lead to a second capture.
        if (btn_s_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Capture / handshake registers
  // -------------------------------------------------------------------------
  logic [BUS_WIDTH-1:0] sw_reg;
  logic                 ready_in_reg;
  logic                 overrun_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_reg       <= '0;
      ready_in_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (capture) begin
      // A capture wins over a same-edge ack; an ack on that edge means the
      // old data was consumed, so it is not an overrun.
      sw_reg       <= sw_s;
      ready_in_reg <= 1'b1;
      if (ready_in_reg && !in_ack) begin
        overrun_reg <= 1'b1;
      end
    end else if (ready_in_reg && in_ack) begin
      ready_in_reg <= 1'b0;
    end
  end

  assign sw       = sw_reg;
  assign ready_in = ready_in_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_input_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_port_ctrl
//   Directed self-checking bench for input_port_ctrl (BUS_WIDTH=8, D=4).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_input_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic [7:0] sw_raw;
  logic       in_ack;
  logic [7:0] sw;
  logic       ready_in;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_port_ctrl #(
    .BUS_WIDTH      (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .sw_raw  (sw_raw),
    .in_ack  (in_ack),
    .sw      (sw),
    .ready_in(ready_in),
    .overrun (overrun)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // T1: reset held with button pressed and switches all ones
  task automatic test_reset();
    reset = 1'b1; btn_raw = 1'b1; sw_raw = 8'hFF; in_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (sw !== 8'h00) begin errors++; $display("FAIL reset_sw cyc %0d: got %h expected 00", i, sw); end
      checks++;
      if (ready_in !== 1'b0) begin errors++; $display("FAIL reset_ready cyc %0d: got %b expected 0", i, ready_in); end
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun cyc %0d: got %b expected 0", i, overrun); end
    end
    btn_raw = 1'b0; reset = 1'b0;
    tick(4);
    $display("reset: sw=%h ready_in=%b overrun=%b", sw, ready_in, overrun);
  endtask

  // T2: clean press, exact latency, then a one-cycle ack
  task automatic test_clean_press();
    sw_raw = 8'hA5;
    tick(3);
    btn_raw = 1'b1;
    tick(5);                      // edges 0..4
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL press_early: ready_in got %b expected 0 after edge 4", ready_in); end
    tick(1);                      // edge 5
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL press_ready: got %b expected 1 after edge 5", ready_in); end
    checks++;
    if (sw !== 8'hA5) begin errors++; $display("FAIL press_sw: got %h expected a5", sw); end
    in_ack = 1'b1;
    tick(1);
    in_ack = 1'b0;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL ack_ready: got %b expected 0", ready_in); end
    checks++;
    if (sw !== 8'hA5) begin errors++; $display("FAIL ack_sw_hold: got %h expected a5", sw); end
    btn_raw = 1'b0;
    tick(8);
    $display("clean_press: sw=%h ready_in=%b", sw, ready_in);
  endtask

  // T3: five bursts of three high samples never capture
  task automatic test_bounce();
    int rises = 0;
    logic prev;
    sw_raw = 8'h5A;
    prev = ready_in;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        if (ready_in && !prev) rises++;
        prev = ready_in;
      end
      btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        if (ready_in && !prev) rises++;
        prev = ready_in;
      end
    end
    tick(4);
    checks++;
    if (rises != 0 || ready_in !== 1'b0) begin errors++; $display("FAIL bounce_ready: rises %0d ready_in %b expected 0 and 0", rises, ready_in); end
    checks++;
    if (sw !== 8'hA5) begin errors++; $display("FAIL bounce_sw: got %h expected a5", sw); end
    $display("bounce: rises=%0d sw=%h", rises, sw);
  endtask

  // T4: long hold captures once, short release never recaptures, full
  // release followed by a new press captures again
  task automatic test_long_hold();
    int rises = 0;
    logic prev;
    sw_raw = 8'h77;
    tick(3);
    prev = ready_in;
    btn_raw = 1'b1; in_ack = 1'b1;   // level ack exposes any recapture as a rise
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ready_in && !prev) rises++;
      prev = ready_in;
    end
    in_ack = 1'b0;
    checks++;
    if (rises != 1) begin errors++; $display("FAIL hold_captures: got %0d expected 1", rises); end
    checks++;
    if (sw !== 8'h77) begin errors++; $display("FAIL hold_sw: got %h expected 77", sw); end
    rises = 0;
    btn_raw = 1'b0;
    tick(2);
    btn_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ready_in && !prev) rises++;
      prev = ready_in;
    end
    checks++;
    if (rises != 0 || ready_in !== 1'b0) begin errors++; $display("FAIL short_release: rises %0d ready_in %b expected 0 and 0", rises, ready_in); end
    btn_raw = 1'b0; sw_raw = 8'h3C;
    tick(8);
    btn_raw = 1'b1;
    tick(6);
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL repress_ready: got %b expected 1", ready_in); end
    checks++;
    if (sw !== 8'h3C) begin errors++; $display("FAIL repress_sw: got %h expected 3c", sw); end
    in_ack = 1'b1; tick(1); in_ack = 1'b0;
    btn_raw = 1'b0;
    tick(8);
    $display("long_hold: sw=%h ready_in=%b", sw, ready_in);
  endtask

  // T5: second capture without an ack sets the sticky overrun flag
  task automatic test_overrun();
    sw_raw = 8'h11;
    tick(3);
    btn_raw = 1'b1; tick(6); btn_raw = 1'b0;
    checks++;
    if (sw !== 8'h11 || ready_in !== 1'b1) begin errors++; $display("FAIL ovr_first: sw %h ready_in %b expected 11 and 1", sw, ready_in); end
    sw_raw = 8'h22;
    tick(8);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b expected 0", overrun); end
    btn_raw = 1'b1; tick(6); btn_raw = 1'b0;
    checks++;
    if (sw !== 8'h22) begin errors++; $display("FAIL ovr_sw: got %h expected 22", sw); end
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL ovr_ready: got %b expected 1", ready_in); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    in_ack = 1'b1; tick(1); in_ack = 1'b0;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL ovr_ack_ready: got %b expected 0", ready_in); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    tick(8);
    $display("overrun: sw=%h ready_in=%b overrun=%b", sw, ready_in, overrun);
  endtask

  // T6: ack on the capture edge, and reset in the middle of press debounce
  task automatic test_corner();
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL corner_rst_ovr: got %b expected 0", overrun); end
    sw_raw = 8'h99;
    tick(3);
    btn_raw = 1'b1; tick(6); btn_raw = 1'b0;
    sw_raw = 8'h66;
    tick(8);
    btn_raw = 1'b1;
    tick(5);
    in_ack = 1'b1;
    tick(1);                      // capture edge with ack
    in_ack = 1'b0;
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b expected 1", ready_in); end
    checks++;
    if (sw !== 8'h66) begin errors++; $display("FAIL simul_sw: got %h expected 66", sw); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
    in_ack = 1'b1; tick(1); in_ack = 1'b0;
    btn_raw = 1'b0;
    tick(8);

    // Reset lands on edge 4, while the FSM sits in PRESS_DB with cnt=2
    sw_raw = 8'h42;
    tick(3);
    btn_raw = 1'b1;
    tick(4);
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++;
    if (ready_in !== 1'b0 || sw !== 8'h00) begin errors++; $display("FAIL midrst_clear: ready_in %b sw %h expected 0 and 00", ready_in, sw); end
    tick(5);
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b expected 0", ready_in); end
    tick(1);
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_in); end
    checks++;
    if (sw !== 8'h42) begin errors++; $display("FAIL midrst_sw: got %h expected 42", sw); end
    btn_raw = 1'b0;
    tick(4);
    $display("corner: sw=%h ready_in=%b overrun=%b", sw, ready_in, overrun);
  endtask

  initial begin
    reset = 1'b1; btn_raw = 1'b0; sw_raw = 8'h00; in_ack = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_overrun();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
